// File: rtl/multi_edge_detect.sv
// multi_edge_detect: per-channel synchronised edge detector with mode-selected event
// pulses, sticky status and interrupt. Optional debounce filter: MULTI_EDGE_DETECT_FILTER_EN.
module multi_edge_detect #(
  parameter int CH       = 8,
  parameter int FILT_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   din,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   rise_o,
  output logic [CH-1:0]   fall_o,
  output logic [CH-1:0]   event_o,
  output logic [CH-1:0]   status_o,
  output logic            irq_o
);

  logic [CH-1:0] sync1_p0;
  logic [CH-1:0] sync2_p1;
  logic [CH-1:0] stable;
  logic [CH-1:0] stable_d_p2;
  logic [CH-1:0] rise_nxt;
  logic [CH-1:0] fall_nxt;
  logic [CH-1:0] event_nxt;

  // Mode bit 2i enables rising edges of channel i, bit 2i+1 enables falling edges.
  function automatic logic [CH-1:0] pick_events(
    input logic [CH-1:0]   r,
    input logic [CH-1:0]   f,
    input logic [2*CH-1:0] m
  );
    logic [CH-1:0] e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      e[i] = (r[i] & m[2*i]) | (f[i] & m[2*i+1]);
    end
    return e;
  endfunction

  // Stage p0/p1: two-flop synchroniser on the raw asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= din;
      sync2_p1 <= sync1_p0;
    end
  end

`ifdef MULTI_EDGE_DETECT_FILTER_EN
  localparam logic [7:0] FILT_LAST = 8'(FILT_CYC - 1);

  logic [7:0] cnt [CH];

  function automatic logic [7:0] cnt_step(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Debounce: stable follows sync2 only after FILT_CYC consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sync2_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FILT_LAST) begin
          stable[i] <= sync2_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt_step(cnt[i]);
        end
      end
    end
  end
`else
  logic [7:0] unused_filt_cyc;

  assign unused_filt_cyc = 8'(FILT_CYC);
  assign stable          = sync2_p1;
`endif

  always_comb begin
    rise_nxt  = stable & ~stable_d_p2;
    fall_nxt  = ~stable & stable_d_p2;
    event_nxt = pick_events(rise_nxt, fall_nxt, mode);
  end

  // Stage p2: delayed level and registered edge/event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_d_p2 <= '0;
      rise_o      <= '0;
      fall_o      <= '0;
      event_o     <= '0;
    end else begin
      stable_d_p2 <= stable;
      rise_o      <= rise_nxt;
      fall_o      <= fall_nxt;
      event_o     <= event_nxt;
    end
  end

  // Stage p3: sticky status; a new event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      status_o <= '0;
    end else begin
      status_o <= (status_o & ~clr) | event_o;
    end
  end

  assign irq_o = |status_o;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect: table-driven edge vectors, a per-cycle
// scoreboard of expected pulses/status, and hand sequences for reset and filter corners.
module tb_multi_edge_detect;
  localparam int CH   = 8;
  localparam int FILT = 4;
`ifdef MULTI_EDGE_DETECT_FILTER_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   din;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   rise_o;
  logic [CH-1:0]   fall_o;
  logic [CH-1:0]   event_o;
  logic [CH-1:0]   status_o;
  logic            irq_o;

  multi_edge_detect #(.CH(CH), .FILT_CYC(FILT)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .rise_o(rise_o), .fall_o(fall_o), .event_o(event_o),
    .status_o(status_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int            due;
    logic [CH-1:0] r;
    logic [CH-1:0] f;
    logic [CH-1:0] e;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [CH-1:0]   din;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   r;
    logic [CH-1:0]   f;
    logic [CH-1:0]   e;
  } vec_t;

  vec_t vec [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic expect_pulse(input int due, input logic [CH-1:0] r,
                              input logic [CH-1:0] f, input logic [CH-1:0] e);
    exp_t x;
    x.due = due;
    x.r   = r;
    x.f   = f;
    x.e   = e;
    sbq.push_back(x);
  endtask

  // Scoreboard: pulses are zero except where an expectation falls due; status is sticky.
  logic [CH-1:0] st_exp    = '0;
  logic          rst_seen  = 1'b1;
  always @(negedge clk) begin
    logic [CH-1:0] er;
    logic [CH-1:0] ef;
    logic [CH-1:0] ee;
    er = '0;
    ef = '0;
    ee = '0;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      if (sbq[0].due == cyc && !rst_seen) begin
        er = er | sbq[0].r;
        ef = ef | sbq[0].f;
        ee = ee | sbq[0].e;
      end
      void'(sbq.pop_front());
    end
    check("sb_rise_o",   32'(rise_o),   32'(er));
    check("sb_fall_o",   32'(fall_o),   32'(ef));
    check("sb_event_o",  32'(event_o),  32'(ee));
    check("sb_status_o", 32'(status_o), 32'(st_exp));
    check("sb_irq_o",    32'(irq_o),    32'(|st_exp));
    st_exp   = rst ? '0 : ((st_exp & ~clr) | ee);
    rst_seen = rst;
  end

  initial begin
    int t0;
    vec[0]  = '{8'h01, 16'h0001, 8'h00, 8'h01, 8'h00, 8'h01};
    vec[1]  = '{8'h00, 16'h0001, 8'h00, 8'h00, 8'h01, 8'h00};
    vec[2]  = '{8'h02, 16'h0008, 8'h00, 8'h02, 8'h00, 8'h00};
    vec[3]  = '{8'h00, 16'h0008, 8'h02, 8'h00, 8'h02, 8'h02};
    vec[4]  = '{8'hAA, 16'hFFFF, 8'h00, 8'hAA, 8'h00, 8'hAA};
    vec[5]  = '{8'h55, 16'hFFFF, 8'h00, 8'h55, 8'hAA, 8'hFF};
    vec[6]  = '{8'h0F, 16'h5555, 8'h00, 8'h0A, 8'h50, 8'h0A};
    vec[7]  = '{8'hF0, 16'hAAAA, 8'hFF, 8'hF0, 8'h0F, 8'h0F};
    vec[8]  = '{8'h10, 16'h0000, 8'h00, 8'h00, 8'hE0, 8'h00};
    vec[9]  = '{8'h00, 16'h0000, 8'h00, 8'h00, 8'h10, 8'h00};
    vec[10] = '{8'h10, 16'h0000, 8'hFF, 8'h10, 8'h00, 8'h00};

    rst  = 1'b1;
    din  = '0;
    mode = '0;
    clr  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rise",   32'(rise_o),   32'h0);
    check("reset_status", 32'(status_o), 32'h0);
    check("reset_irq",    32'(irq_o),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      mode = vec[k].mode;
      din  = vec[k].din;
      expect_pulse(cyc + LAT, vec[k].r, vec[k].f, vec[k].e);
      repeat (LAT + 1) @(posedge clk);
      #1;
      clr = vec[k].clr;
      @(posedge clk); #1;
      clr = '0;
      @(posedge clk);
    end
    @(negedge clk);
    check("mode_off_status", 32'(status_o), 32'h0);

    // Event and clear in the same cycle on channel 3: the set must win
    @(posedge clk); #1;
    mode = 16'h0040;
    din  = 8'h18;
    expect_pulse(cyc + LAT, 8'h08, 8'h00, 8'h08);
    repeat (LAT) @(posedge clk);
    #1;
    clr = 8'h08;
    @(negedge clk);
    check("setwin_event", 32'(event_o[3]), 32'h1);
    @(posedge clk); #1;
    clr = '0;
    @(negedge clk);
    check("setwin_status", 32'(status_o[3]), 32'h1);
    check("setwin_irq",    32'(irq_o),       32'h1);
    @(posedge clk); #1;
    clr = 8'h08;
    @(posedge clk); #1;
    clr = '0;
    @(negedge clk);
    check("clr_status", 32'(status_o), 32'h0);
    check("clr_irq",    32'(irq_o),    32'h0);

    // Short glitch then a long pulse on channel 2
    @(posedge clk); #1;
    mode = 16'h0030;
    din  = 8'h1C;
    t0   = cyc;
`ifndef MULTI_EDGE_DETECT_FILTER_EN
    expect_pulse(t0 + LAT,     8'h04, 8'h00, 8'h04);
    expect_pulse(t0 + 3 + LAT, 8'h00, 8'h04, 8'h04);
`endif
    repeat (3) @(posedge clk);
    #1;
    din = 8'h18;
    repeat (LAT + 4) @(posedge clk);
    #1;
    din = 8'h1C;
    t0  = cyc;
    expect_pulse(t0 + LAT,     8'h04, 8'h00, 8'h04);
    expect_pulse(t0 + 6 + LAT, 8'h00, 8'h04, 8'h04);
    repeat (6) @(posedge clk);
    #1;
    din = 8'h18;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    check("pulse_status", 32'(status_o[2]), 32'h1);

    // All inputs high through reset release
    @(posedge clk); #1;
    rst  = 1'b1;
    din  = 8'hFF;
    mode = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("inrst_rise",   32'(rise_o),   32'h0);
    check("inrst_status", 32'(status_o), 32'h0);
    check("inrst_irq",    32'(irq_o),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_pulse(cyc + LAT, 8'hFF, 8'h00, 8'hFF);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("release_rise", 32'(rise_o), 32'hFF);
    @(negedge clk);
    check("release_rise_once", 32'(rise_o),   32'h0);
    check("release_status",    32'(status_o), 32'hFF);
    repeat (3) @(posedge clk);

    // Reset arriving while an edge is still travelling through the pipeline
    @(posedge clk); #1;
    din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_fall",   32'(fall_o),   32'h0);
    check("midrst_event",  32'(event_o),  32'h0);
    check("midrst_status", 32'(status_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    @(negedge clk);
    check("after_midrst_fall", 32'(fall_o), 32'h0);
    check("after_midrst_irq",  32'(irq_o),  32'h0);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
